// File: rtl/beep_seq_if.sv
// ----------------------------------------------------------------------------
// beep_seq_if -- note request channel for the beep_seq buzzer sequencer.
//
// A note is a (half-period, duration) pair offered with a valid/ready
// handshake; it is transferred on any rising edge where both are high.
//
// Signals:
//   req_valid        producer -> sequencer  note request valid
//   req_ready        sequencer -> producer  note FIFO can accept a note
//   req_half_period  producer -> sequencer  tone half-period in clock cycles, 0 = rest
//   req_dur_ms       producer -> sequencer  note duration in milliseconds
//
// Modports:
//   master  the note producer
//   slave   the sequencer (beep_seq)
// ----------------------------------------------------------------------------
interface beep_seq_if #(
    parameter int HP_W  = 32,
    parameter int DUR_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [HP_W-1:0]  req_half_period;
    logic [DUR_W-1:0] req_dur_ms;

    modport master (
        output req_valid,
        output req_half_period,
        output req_dur_ms,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_half_period,
        input  req_dur_ms,
        output req_ready
    );
endinterface

// File: rtl/beep_seq.sv
// ----------------------------------------------------------------------------
// beep_seq -- queued buzzer note sequencer.
//
// Notes arrive over a valid/ready channel into a small FIFO and are played
// one after another as a square wave on an active-low buzzer output. Each
// note toggles the output every half-period clock cycles for a duration
// measured in milliseconds; a half-period of zero is a silent rest.
//
// Optional feature (compile-time macro BEEP_GAP_EN):
//   defined   -> a silent GAP of GAP_MS milliseconds follows every note
//   undefined -> the next queued note starts on the cycle after a note ends
//
// Parameters:
//   CLK_FREQ  sys_clk frequency in Hz (1 ms = CLK_FREQ/1000 cycles)
//   HP_W      half-period field width
//   DUR_W     duration field width (ms)
//   DEPTH     note FIFO depth, power of two, >= 2
//   GAP_MS    inter-note silence in ms (BEEP_GAP_EN builds only)
//
// Ports:
//   sys_clk     in   sole clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   req         if   note request channel (beep_seq_if.slave)
//   abort       in   flush the queue and silence the output
//   beep        out  buzzer drive, active-low, idles at 1
//   busy        out  high while a note/gap is in progress or notes are queued
//   fifo_level  out  number of queued notes
// ----------------------------------------------------------------------------
module beep_seq #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int HP_W     = 32,
    parameter int DUR_W    = 16,
    parameter int DEPTH    = 4,
    parameter int GAP_MS   = 20
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    beep_seq_if.slave                req,
    input  logic                     abort,
    output logic                     beep,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int MS_CYC = CLK_FREQ / 1000;
    localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_CYC - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("beep_seq: DEPTH must be a power of two >= 2");
    end
    if (CLK_FREQ < 1000 || GAP_MS < 0) begin : g_bad_timing
        $error("beep_seq: CLK_FREQ must be >= 1000 and GAP_MS >= 0");
    end

`ifdef BEEP_GAP_EN
    localparam int GAP_W = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TONE,
        S_GAP
    } state_t;
`else
    typedef enum logic {
        S_IDLE,
        S_TONE
    } state_t;
`endif

    // Note FIFO
    logic [HP_W-1:0]  mem_hp  [DEPTH];
    logic [DUR_W-1:0] mem_dur [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             rdy_en;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Note being played
    logic [HP_W-1:0]  hp_q;
    logic [DUR_W-1:0] dur_q;

    // Sequencer state and counters
    state_t           state;
    logic             beep_q;
    logic [HP_W-1:0]  tone_cnt;
    logic [MS_W-1:0]  ms_cnt;
    logic [DUR_W-1:0] dur_cnt;
`ifdef BEEP_GAP_EN
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_end;
`endif
    logic             ms_tick;
    logic             tone_end;
    logic             tone_flip;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == LVL_W'(DEPTH));

    // rdy_en keeps ready low for the whole time reset is asserted; it rises
    // on the first clock edge after release.
    assign req.req_ready = rdy_en && !fifo_full && !abort;
    assign push          = req.req_valid && req.req_ready;

    assign ms_tick   = (ms_cnt == MS_LAST);
    // A zero-length note ends on its first TONE cycle; otherwise the note
    // ends on the ms tick that completes its last millisecond.
    assign tone_end  = (dur_q == '0) || (ms_tick && (dur_cnt == dur_q - DUR_W'(1)));
    assign tone_flip = (hp_q != '0) && (tone_cnt == hp_q - HP_W'(1));
`ifdef BEEP_GAP_EN
    assign gap_end   = (GAP_MS == 0) || (ms_tick && (gap_cnt == GAP_LAST));
`endif

    // Head-of-queue fetch: from IDLE, or straight from the end of a tone
    // when there is no inter-note gap. abort suppresses any fetch.
    always_comb begin
        pop = 1'b0;
        if (!abort && !fifo_empty) begin
            if (state == S_IDLE) begin
                pop = 1'b1;
            end
`ifndef BEEP_GAP_EN
            if (state == S_TONE && tone_end) begin
                pop = 1'b1;
            end
`endif
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdy_en <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + LVL_W'(1);
                    2'b01:   count <= count - LVL_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage and current-note registers (data only, no reset)
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_hp[wr_ptr]  <= req.req_half_period;
            mem_dur[wr_ptr] <= req.req_dur_ms;
        end
        if (pop) begin
            hp_q  <= mem_hp[rd_ptr];
            dur_q <= mem_dur[rd_ptr];
        end
    end

    // Sequencer FSM with registered buzzer output
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            beep_q   <= 1'b1;
            tone_cnt <= '0;
            ms_cnt   <= '0;
            dur_cnt  <= '0;
`ifdef BEEP_GAP_EN
            gap_cnt  <= '0;
`endif
        end else if (abort) begin
            state    <= S_IDLE;
            beep_q   <= 1'b1;
            tone_cnt <= '0;
            ms_cnt   <= '0;
            dur_cnt  <= '0;
`ifdef BEEP_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state    <= S_TONE;
                        beep_q   <= 1'b1;
                        tone_cnt <= '0;
                        ms_cnt   <= '0;
                        dur_cnt  <= '0;
                    end
                end

                S_TONE: begin
                    if (tone_end) begin
                        // Output returns high on the cycle after the note,
                        // and every counter restarts from zero for whatever
                        // comes next.
                        beep_q   <= 1'b1;
                        tone_cnt <= '0;
                        ms_cnt   <= '0;
                        dur_cnt  <= '0;
`ifdef BEEP_GAP_EN
                        state    <= S_GAP;
                        gap_cnt  <= '0;
`else
                        state    <= pop ? S_TONE : S_IDLE;
`endif
                    end else begin
                        ms_cnt <= ms_tick ? '0 : ms_cnt + MS_W'(1);
                        if (ms_tick) begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                        if (tone_flip) begin
                            tone_cnt <= '0;
                            beep_q   <= ~beep_q;
                        end else if (hp_q != '0) begin
                            tone_cnt <= tone_cnt + HP_W'(1);
                        end
                    end
                end

`ifdef BEEP_GAP_EN
                S_GAP: begin
                    if (gap_end) begin
                        state   <= S_IDLE;
                        ms_cnt  <= '0;
                        gap_cnt <= '0;
                    end else begin
                        ms_cnt <= ms_tick ? '0 : ms_cnt + MS_W'(1);
                        if (ms_tick) begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign beep       = beep_q;
    assign busy       = (state != S_IDLE) || !fifo_empty;
    assign fifo_level = count;

endmodule

// File: tb/tb_beep_seq.sv
// ----------------------------------------------------------------------------
// tb_beep_seq -- self-checking bench for beep_seq.
// CLK_FREQ = 10_000 so one millisecond is 10 sys_clk cycles.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. "Cycle c" of a scenario is the clock period whose closing
// rising edge samples the inputs driven at its start.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_beep_seq;

    localparam int CLK_FREQ = 10_000;
    localparam int HP_W     = 32;
    localparam int DUR_W    = 16;
    localparam int DEPTH    = 4;
    localparam int GAP_MS   = 20;
    localparam int LVL_W    = $clog2(DEPTH) + 1;

`ifdef BEEP_GAP_EN
    localparam int GAP_CYC  = GAP_MS * CLK_FREQ / 1000;
    localparam int EXTRA    = GAP_CYC + 1;   // gap plus the IDLE fetch cycle
`else
    localparam int GAP_CYC  = 0;
    localparam int EXTRA    = 0;
`endif

    typedef struct {
        logic beep;
        logic busy;
    } exp_t;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             abort;
    logic             beep;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    int n_checks;
    int n_pass;

    exp_t sb_q[$];
    int   lvl_q[$];

    beep_seq_if #(.HP_W(HP_W), .DUR_W(DUR_W)) req_if ();

    beep_seq #(
        .CLK_FREQ (CLK_FREQ),
        .HP_W     (HP_W),
        .DUR_W    (DUR_W),
        .DEPTH    (DEPTH),
        .GAP_MS   (GAP_MS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req        (req_if.slave),
        .abort      (abort),
        .beep       (beep),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Expected buzzer level k cycles after TONE entry for half-period hp.
    function automatic logic wave(input int hp, input int k);
        return (hp == 0) ? 1'b1 : (((k / hp) % 2) == 0);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_note(input int hp, input int dur);
        req_if.req_valid       = 1'b1;
        req_if.req_half_period = HP_W'(hp);
        req_if.req_dur_ms      = DUR_W'(dur);
    endtask

    task automatic idle_inputs();
        req_if.req_valid       = 1'b0;
        req_if.req_half_period = '0;
        req_if.req_dur_ms      = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge sys_clk);
        while (busy && n < 5000) begin
            step();
            @(negedge sys_clk);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL wait_idle busy=%b required 0 after %0d cycles", busy, n);
        else n_pass++;
        step();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        abort     = 1'b0;
        idle_inputs();
        step();
        step();
        @(negedge sys_clk);
        n_checks++;
        if (beep !== 1'b1) $display("FAIL rst_beep got=%b exp=1", beep);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
        else n_pass++;
        n_checks++;
        if (fifo_level !== LVL_W'(0)) $display("FAIL rst_level got=%0d exp=0", fifo_level);
        else n_pass++;
        n_checks++;
        if (req_if.req_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", req_if.req_ready);
        else n_pass++;
        #1 sys_rst_n = 1'b1;
        step();
        n_checks++;
        if (req_if.req_ready !== 1'b1) $display("FAIL rst_ready_after got=%b exp=1", req_if.req_ready);
        else n_pass++;
    endtask

    task automatic test_single_tone();
        exp_t e;
        sb_q.delete();
        drive_note(3, 2);
        for (int c = 0; c < 23 + GAP_CYC; c++) begin
            e.beep = (c >= 2 && c <= 21) ? wave(3, c - 2) : 1'b1;
            e.busy = (c >= 1 && c <= 21 + GAP_CYC);
            sb_q.push_back(e);
        end
        for (int c = 0; c < 23 + GAP_CYC; c++) begin
            @(negedge sys_clk);
            e = sb_q.pop_front();
            n_checks++;
            if (beep !== e.beep) $display("FAIL tone_beep c=%0d got=%b exp=%b", c, beep, e.beep);
            else n_pass++;
            n_checks++;
            if (busy !== e.busy) $display("FAIL tone_busy c=%0d got=%b exp=%b", c, busy, e.busy);
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if (fifo_level !== LVL_W'(1)) $display("FAIL tone_level_queued got=%0d exp=1", fifo_level);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (fifo_level !== LVL_W'(0)) $display("FAIL tone_level_popped got=%0d exp=0", fifo_level);
                else n_pass++;
            end
            step();
            if (c == 0) idle_inputs();
        end
    endtask

    task automatic test_rest();
        exp_t e;
        sb_q.delete();
        drive_note(0, 3);
        for (int c = 0; c < 33 + GAP_CYC; c++) begin
            e.beep = 1'b1;
            e.busy = (c >= 1 && c <= 31 + GAP_CYC);
            sb_q.push_back(e);
        end
        for (int c = 0; c < 33 + GAP_CYC; c++) begin
            @(negedge sys_clk);
            e = sb_q.pop_front();
            n_checks++;
            if (beep !== e.beep) $display("FAIL rest_beep c=%0d got=%b exp=%b", c, beep, e.beep);
            else n_pass++;
            n_checks++;
            if (busy !== e.busy) $display("FAIL rest_busy c=%0d got=%b exp=%b", c, busy, e.busy);
            else n_pass++;
            step();
            if (c == 0) idle_inputs();
        end
    endtask

    task automatic test_zero_dur();
`ifndef BEEP_GAP_EN
        exp_t e;
        sb_q.delete();
        drive_note(5, 0);
        for (int c = 0; c < 14; c++) begin
            e.beep = (c >= 3 && c <= 12) ? wave(2, c - 3) : 1'b1;
            e.busy = (c >= 1 && c <= 12);
            sb_q.push_back(e);
        end
        for (int c = 0; c < 14; c++) begin
            @(negedge sys_clk);
            e = sb_q.pop_front();
            n_checks++;
            if (beep !== e.beep) $display("FAIL zdur_beep c=%0d got=%b exp=%b", c, beep, e.beep);
            else n_pass++;
            n_checks++;
            if (busy !== e.busy) $display("FAIL zdur_busy c=%0d got=%b exp=%b", c, busy, e.busy);
            else n_pass++;
            step();
            if (c == 0) drive_note(2, 1);
            if (c == 1) idle_inputs();
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        int ready_cyc;
        int busy_low_cyc;
        ready_cyc    = 32 + EXTRA;
        busy_low_cyc = 82 + 5 * EXTRA + GAP_CYC;
        lvl_q.delete();
        drive_note(4, 3);
        cyc = 0;
        step();
        cyc = 1;
        idle_inputs();
        step();
        cyc = 2;
        drive_note(2, 1);
        for (int k = 1; k <= 4; k++) begin
            lvl_q.push_back(k);
            step();
            cyc++;
            @(negedge sys_clk);
            n_checks++;
            if (fifo_level !== LVL_W'(lvl_q[0])) $display("FAIL b2b_level k=%0d got=%0d exp=%0d", k, fifo_level, lvl_q[0]);
            else n_pass++;
            void'(lvl_q.pop_front());
        end
        n_checks++;
        if (req_if.req_ready !== 1'b0) $display("FAIL b2b_ready_full got=%b exp=0", req_if.req_ready);
        else n_pass++;
        while (req_if.req_ready !== 1'b1 && cyc < ready_cyc + 50) begin
            step();
            cyc++;
            @(negedge sys_clk);
        end
        n_checks++;
        if (cyc !== ready_cyc) $display("FAIL b2b_ready_cycle got=%0d exp=%0d", cyc, ready_cyc);
        else n_pass++;
        n_checks++;
        if (fifo_level !== LVL_W'(3)) $display("FAIL b2b_level_after_pop got=%0d exp=3", fifo_level);
        else n_pass++;
        step();
        cyc++;
        idle_inputs();
        @(negedge sys_clk);
        n_checks++;
        if (fifo_level !== LVL_W'(4)) $display("FAIL b2b_fifth_stored got=%0d exp=4", fifo_level);
        else n_pass++;
        while (busy !== 1'b0 && cyc < busy_low_cyc + 100) begin
            step();
            cyc++;
            @(negedge sys_clk);
        end
        n_checks++;
        if (cyc !== busy_low_cyc) $display("FAIL b2b_drain_cycle got=%0d exp=%0d", cyc, busy_low_cyc);
        else n_pass++;
        step();
    endtask

    task automatic test_abort();
        drive_note(2, 5);
        step();
        step();
        step();
        idle_inputs();
        for (int i = 0; i < 5; i++) step();
        abort = 1'b1;
        drive_note(7, 7);
        @(negedge sys_clk);
        n_checks++;
        if (beep !== 1'b0) $display("FAIL abort_pre_beep got=%b exp=0", beep);
        else n_pass++;
        n_checks++;
        if (fifo_level !== LVL_W'(2)) $display("FAIL abort_pre_level got=%0d exp=2", fifo_level);
        else n_pass++;
        n_checks++;
        if (req_if.req_ready !== 1'b0) $display("FAIL abort_ready got=%b exp=0", req_if.req_ready);
        else n_pass++;
        step();
        abort = 1'b0;
        idle_inputs();
        @(negedge sys_clk);
        n_checks++;
        if (beep !== 1'b1) $display("FAIL abort_beep got=%b exp=1", beep);
        else n_pass++;
        n_checks++;
        if (fifo_level !== LVL_W'(0)) $display("FAIL abort_level got=%0d exp=0", fifo_level);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge sys_clk);
            n_checks++;
            if (busy !== 1'b0 || beep !== 1'b1) $display("FAIL abort_after i=%0d busy=%b beep=%b exp busy=0 beep=1", i, busy, beep);
            else n_pass++;
        end
        step();
    endtask

    task automatic test_async_reset();
        drive_note(2, 5);
        step();
        step();
        idle_inputs();
        step();
        step();
        @(negedge sys_clk);
        n_checks++;
        if (beep !== 1'b0 || fifo_level !== LVL_W'(1)) $display("FAIL arst_pre beep=%b level=%0d exp beep=0 level=1", beep, fifo_level);
        else n_pass++;
        #1 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (beep !== 1'b1) $display("FAIL arst_beep got=%b exp=1", beep);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL arst_busy got=%b exp=0", busy);
        else n_pass++;
        n_checks++;
        if (fifo_level !== LVL_W'(0)) $display("FAIL arst_level got=%0d exp=0", fifo_level);
        else n_pass++;
        n_checks++;
        if (req_if.req_ready !== 1'b0) $display("FAIL arst_ready got=%b exp=0", req_if.req_ready);
        else n_pass++;
        #1 sys_rst_n = 1'b1;
        step();
        n_checks++;
        if (req_if.req_ready !== 1'b1) $display("FAIL arst_ready_after got=%b exp=1", req_if.req_ready);
        else n_pass++;
        step();
        @(negedge sys_clk);
        n_checks++;
        if (busy !== 1'b0 || beep !== 1'b1) $display("FAIL arst_queue_lost busy=%b beep=%b exp busy=0 beep=1", busy, beep);
        else n_pass++;
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        sys_rst_n = 1'b0;
        abort     = 1'b0;
        idle_inputs();
        test_reset();
        wait_idle();
        test_single_tone();
        wait_idle();
        test_rest();
        wait_idle();
        test_zero_dur();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_abort();
        wait_idle();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/beep_seq.md
BEEP_SEQ -- requirements
Module: beep_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter HP_W, default 32, meaning half-period field width.
REQ-003 SHALL have parameter DUR_W, default 16, meaning duration field width, in ms.
REQ-004 SHALL have parameter DEPTH, default 4, meaning note FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameter GAP_MS, default 20, meaning silent gap between notes in ms.
REQ-006 SHALL have port sys_clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port req_valid  in  1  note request valid.
REQ-009 SHALL have port req_ready  out  1  FIFO can accept a note.
REQ-010 SHALL have port req_half_period  in  HP_W  tone half-period in sys_clk cycles; 0 = rest.
REQ-011 SHALL have port req_dur_ms  in  DUR_W  note duration in ms.
REQ-012 SHALL have port abort  in  1  flush queue and silence output.
REQ-013 SHALL have port beep  out  1  buzzer drive, active-low, idle 1.
REQ-014 SHALL have port busy  out  1  high when not IDLE or FIFO non-empty.
REQ-015 SHALL have port fifo_level  out  $clog2(DEPTH)+1  entries queued.

Function
REQ-016 SHALL write the FIFO on req_valid && req_ready; req_ready = !full && !abort.
REQ-017 SHALL implement FSM states IDLE, TONE, GAP.
REQ-018 IDLE: on FIFO non-empty, SHALL pop the head and enter TONE next cycle with half-period/duration loaded; a note pushed at cycle N into an empty FIFO enters TONE at cycle N+2.
REQ-019 Pop and push in the same cycle SHALL leave fifo_level unchanged.
REQ-020 TONE: tone counter SHALL count 0..hp-1 and toggle beep and clear on hp-1; first toggle hp cycles after TONE entry; beep starts at 1.
REQ-021 TONE with hp==0 or hp==1: hp==0 SHALL hold beep at 1; hp==1 SHALL toggle every cycle.
REQ-022 Ms prescaler SHALL count 0..CLK_FREQ/1000-1 from 0 at TONE/GAP entry; each wrap is one ms tick.
REQ-023 TONE SHALL end on the tick completing req_dur_ms ms (exactly dur*CLK_FREQ/1000 cycles); beep SHALL be 1 on the cycle after.
REQ-024 A note with req_dur_ms==0 SHALL occupy TONE for one cycle with beep held 1.
REQ-025 On TONE end, SHALL go to GAP (if enabled per REQ-032) else to IDLE-equivalent next-note fetch (TONE again next cycle if FIFO non-empty).
REQ-026 GAP: beep SHALL be held 1 for GAP_MS ms, then IDLE.
REQ-027 abort SHALL, next cycle, empty the FIFO, force beep=1, reset all counters, enter IDLE; abort wins over a simultaneous push (push dropped).
REQ-028 Counters SHALL be sized to parameter widths; no wrap of duration counter within DUR_W range.

Reset
REQ-029 On sys_rst_n low, asynchronously: beep=1, busy=0, fifo_level=0, req_ready=0 while asserted, FSM=IDLE, all counters 0.
REQ-030 Reset mid-note SHALL silence beep immediately without waiting for a clock; queued notes are lost.
REQ-031 After deassertion req_ready SHALL be 1 on the first clock edge.

Configuration
REQ-032 Macro BEEP_GAP_EN: defined -> GAP state and GAP_MS inter-note silence present; undefined -> GAP state and its counter omitted, TONE end goes directly to next note fetch, GAP_MS ignored.

Verification (bench uses CLK_FREQ=10_000 so 1 ms = 10 cycles)
REQ-033 Push {hp=3, dur=2} into empty idle block at cycle 0 -> TONE entry at cycle 2, beep toggles every 3 cycles for 20 cycles, then beep=1; with BEEP_GAP_EN busy stays high 200 further cycles (GAP_MS=20).
REQ-034 Push 5 notes back-to-back with DEPTH=4 while busy -> req_ready low after 4th stored entry, fifo_level=4, 5th accepted only after a pop.
REQ-035 Push {hp=0, dur=3} -> beep constant 1 for 30 cycles, busy high throughout.
REQ-036 abort asserted mid-tone with 2 queued notes and simultaneous req_valid -> next cycle beep=1, fifo_level=0, IDLE, pushed note not stored.
REQ-037 sys_rst_n pulsed low between clock edges during a tone -> beep=1 immediately, all outputs at reset values, first clock after release req_ready=1.
REQ-038 Push {hp=5, dur=0} followed by {hp=2, dur=1} without BEEP_GAP_EN -> first note silent one cycle, second tone starts the next cycle and lasts 10 cycles.
